// File: rtl/tx_nibble_feeder.sv
// tx_nibble_feeder
//   Feeds one transmit lane's 4:1 serializer. Parallel words arrive over a
//   valid/ready handshake into a small word FIFO. A shifter then sends each
//   word as one 4-bit nibble per clk, least significant nibble first. When no
//   word is available the lane carries IDLE_PAT. pwd gates the lane: it
//   flushes the FIFO, drops any word in flight and drives the serializer
//   power-down.
//
// Ports
//   clk        lane word clock (serializer domain)
//   rst_n      asynchronous active-low reset
//   pwd        lane power-down request, sampled every clk
//   in_valid   input word valid
//   in_ready   input word ready (!full && !pwd)
//   in_data    input word, WORD_W bits
//   ser_data   registered nibble to the serializer data port
//   ser_pwd    registered serializer power-down
//   busy       shifter holds a word being sent
//   fifo_level words currently stored in the FIFO
//
// States
//   S_IDLE | no word in the shifter; drive IDLE_PAT (or 0 while powered down)
//   S_SEND | shifter holds a word; one nibble per clk, cnt = nibble on ser_data
module tx_nibble_feeder #(
  parameter int         WORD_W     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_PAT   = 4'b0101
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pwd,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_data,
  output logic [3:0]                    ser_data,
  output logic                          ser_pwd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NIB = WORD_W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [WORD_W-1:0]   shreg, shreg_nxt;
  logic [3:0]          ser_data_nxt;
  logic [AW:0]         wptr, rptr, rptr_nxt;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [WORD_W-1:0]   rd_word;
  logic                full, empty, push, pop;

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  assign fifo_level = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign in_ready   = !full && !pwd;
  assign push       = in_valid && in_ready;
  assign rd_word    = mem[rptr[AW-1:0]];
  assign busy       = (state == S_SEND);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    ser_data_nxt = ser_data;
    rptr_nxt     = rptr;
    pop          = 1'b0;

    if (pwd) begin
      // Flush and drop the word in flight; nothing is completed partially.
      state_nxt    = S_IDLE;
      cnt_nxt      = '0;
      ser_data_nxt = 4'b0;
      rptr_nxt     = wptr;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            pop          = 1'b1;
            cnt_nxt      = '0;
            ser_data_nxt = rd_word[3:0];
            shreg_nxt    = rd_word >> 4;
            state_nxt    = S_SEND;
          end else begin
            ser_data_nxt = IDLE_PAT;
          end
        end
        S_SEND: begin
          if (cnt != CNT_LAST) begin
            cnt_nxt      = cnt + 1'b1;
            ser_data_nxt = shreg[3:0];
            shreg_nxt    = shreg >> 4;
          end else if (!empty) begin
            // Reload straight from the FIFO so back-to-back words have no gap.
            pop          = 1'b1;
            cnt_nxt      = '0;
            ser_data_nxt = rd_word[3:0];
            shreg_nxt    = rd_word >> 4;
          end else begin
            state_nxt    = S_IDLE;
            ser_data_nxt = IDLE_PAT;
          end
        end
      endcase
      if (pop) rptr_nxt = rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      ser_data <= 4'b0;
      ser_pwd  <= 1'b1;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shreg    <= shreg_nxt;
      ser_data <= ser_data_nxt;
      ser_pwd  <= pwd;
      rptr     <= rptr_nxt;
      if (push) wptr <= wptr + 1'b1;
    end
  end

  // Storage is not reset; zeroed pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_tx_nibble_feeder.sv
// Directed bench for tx_nibble_feeder (WORD_W=16, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tx_nibble_feeder;

  localparam logic [3:0] IDLE_PAT = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwd = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic [3:0]  ser_data;
  logic        ser_pwd;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  got_q[$];
  logic [15:0] exp_q[$];
  bit          cap_en = 1'b0;
  bit          idle_chk_en = 1'b0;
  logic [2:0]  prev_level = 3'd0;

  logic [15:0] w;
  logic [15:0] w3 [5];
  logic [3:0]  nib8 [8];
  logic [2:0]  lv8 [8];
  logic [2:0]  lv5 [5];
  int          sent, cyc, thr;
  bit          acc;

  tx_nibble_feeder #(
    .WORD_W(16),
    .FIFO_DEPTH(4),
    .IDLE_PAT(IDLE_PAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwd(pwd),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .ser_data(ser_data),
    .ser_pwd(ser_pwd),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic bit check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    return (obs === exp);
  endfunction

  // Output monitor: a data nibble is on ser_data exactly when busy is high.
  // An idle nibble may only follow an edge at which the FIFO was empty.
  always @(negedge clk) begin
    if (rst_n && cap_en && busy) got_q.push_back(ser_data);
    if (rst_n && idle_chk_en && !busy) void'(check("idle_only_when_empty", 32'(prev_level), 32'd0));
    prev_level = fifo_level;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a falling edge with the lane idle and the FIFO empty.
  task automatic run_a5c3();
    logic [3:0] nib [4];
    nib[0] = 4'h3; nib[1] = 4'hC; nib[2] = 4'h5; nib[3] = 4'hA;
    in_valid = 1'b1; in_data = 16'hA5C3;
    @(negedge clk);
    in_valid = 1'b0;
    void'(check("s1_level_after_push", 32'(fifo_level), 32'd1));
    void'(check("s1_idle_before_first", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("s1_busy_before_first", 32'(busy), 32'd0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      void'(check("s1_nibble", 32'(ser_data), 32'(nib[i])));
      void'(check("s1_busy", 32'(busy), 32'd1));
    end
    @(negedge clk);
    void'(check("s1_idle_after", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("s1_busy_after", 32'(busy), 32'd0));
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    void'(check("rst_ser_data", 32'(ser_data), 32'd0));
    void'(check("rst_ser_pwd", 32'(ser_pwd), 32'd1));
    void'(check("rst_busy", 32'(busy), 32'd0));
    void'(check("rst_level", 32'(fifo_level), 32'd0));
    void'(check("rst_in_ready", 32'(in_ready), 32'd1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    void'(check("idle_pat_after_rst", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("ser_pwd_after_rst", 32'(ser_pwd), 32'd0));

    // Scenario 1: single word
    run_a5c3();

    // Scenario 2: two words back-to-back, gapless
    nib8[0] = 4'h4; nib8[1] = 4'h3; nib8[2] = 4'h2; nib8[3] = 4'h1;
    nib8[4] = 4'h8; nib8[5] = 4'h7; nib8[6] = 4'h6; nib8[7] = 4'h5;
    lv8[0] = 3'd1; lv8[1] = 3'd1; lv8[2] = 3'd1; lv8[3] = 3'd1;
    lv8[4] = 3'd0; lv8[5] = 3'd0; lv8[6] = 3'd0; lv8[7] = 3'd0;
    in_valid = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    void'(check("s2_ready_second", 32'(in_ready), 32'd1));
    in_data = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      void'(check("s2_nibble", 32'(ser_data), 32'(nib8[i])));
      void'(check("s2_level", 32'(fifo_level), 32'(lv8[i])));
      void'(check("s2_busy", 32'(busy), 32'd1));
      @(negedge clk);
    end
    void'(check("s2_idle_after", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("s2_busy_after", 32'(busy), 32'd0));

    // Scenario 3: fill the FIFO while the shifter is busy
    w3[0] = 16'hC0DE; w3[1] = 16'h1357; w3[2] = 16'h2468; w3[3] = 16'h9ABC; w3[4] = 16'hF00D;
    lv5[0] = 3'd0; lv5[1] = 3'd1; lv5[2] = 3'd1; lv5[3] = 3'd2; lv5[4] = 3'd3;
    got_q.delete();
    cap_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      void'(check("s3_ready", 32'(in_ready), 32'd1));
      void'(check("s3_level", 32'(fifo_level), 32'(lv5[k])));
      in_valid = 1'b1; in_data = w3[k];
      @(negedge clk);
    end
    void'(check("s3_ready_full", 32'(in_ready), 32'd0));
    void'(check("s3_level_full", 32'(fifo_level), 32'd4));
    void'(check("s3_busy_full", 32'(busy), 32'd1));
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    cap_en = 1'b0;
    void'(check("s3_nibble_count", 32'(got_q.size()), 32'd20));
    for (int i = 0; i < got_q.size() && i < 20; i++) begin
      w = w3[i/4];
      if (!check("s3_nibble", 32'(got_q[i]), 32'(w[4*(i%4) +: 4]))) break;
    end
    void'(check("s3_idle_after", 32'(ser_data), 32'(IDLE_PAT)));

    // Scenario 4: power-down at the 2nd nibble of BEEF with one word queued
    in_valid = 1'b1; in_data = 16'hBEEF;
    @(negedge clk);
    in_data = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    void'(check("s4_first_nibble", 32'(ser_data), 32'hF));
    void'(check("s4_level_queued", 32'(fifo_level), 32'd1));
    @(negedge clk);
    void'(check("s4_second_nibble", 32'(ser_data), 32'hE));
    pwd = 1'b1;
    @(negedge clk);
    void'(check("s4_pwd_ser_data", 32'(ser_data), 32'd0));
    void'(check("s4_pwd_ser_pwd", 32'(ser_pwd), 32'd1));
    void'(check("s4_pwd_level", 32'(fifo_level), 32'd0));
    void'(check("s4_pwd_in_ready", 32'(in_ready), 32'd0));
    void'(check("s4_pwd_busy", 32'(busy), 32'd0));
    in_valid = 1'b1; in_data = 16'h7777;
    @(negedge clk);
    void'(check("s4_pwd_no_push", 32'(fifo_level), 32'd0));
    void'(check("s4_pwd_hold", 32'(ser_data), 32'd0));
    pwd = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    void'(check("s4_release_ser_data", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("s4_release_ser_pwd", 32'(ser_pwd), 32'd0));
    void'(check("s4_release_busy", 32'(busy), 32'd0));
    @(negedge clk);
    void'(check("s4_no_leftover_busy", 32'(busy), 32'd0));
    void'(check("s4_no_leftover_data", 32'(ser_data), 32'(IDLE_PAT)));

    // Scenario 5: asynchronous reset mid-word
    in_valid = 1'b1; in_data = 16'h8421;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    void'(check("s5_first_nibble", 32'(ser_data), 32'h1));
    @(negedge clk);
    void'(check("s5_second_nibble", 32'(ser_data), 32'h2));
    #2 rst_n = 1'b0;
    #1;
    void'(check("s5_rst_ser_data", 32'(ser_data), 32'd0));
    void'(check("s5_rst_ser_pwd", 32'(ser_pwd), 32'd1));
    void'(check("s5_rst_busy", 32'(busy), 32'd0));
    void'(check("s5_rst_level", 32'(fifo_level), 32'd0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    void'(check("s5_after_rst_idle", 32'(ser_data), 32'(IDLE_PAT)));
    void'(check("s5_after_rst_busy", 32'(busy), 32'd0));
    void'(check("s5_after_rst_ser_pwd", 32'(ser_pwd), 32'd0));
    run_a5c3();

    // Scenario 6: random traffic with a scoreboard
    exp_q.delete();
    got_q.delete();
    cap_en = 1'b1;
    idle_chk_en = 1'b1;
    sent = 0; cyc = 0; acc = 1'b0;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
      thr = (sent < 300) ? 15 : ((sent < 700) ? 90 : 40);
      if (!in_valid) begin
        if ($urandom_range(0, 99) < thr) begin
          in_valid = 1'b1;
          in_data  = 16'($urandom);
        end
      end else if (!in_ready) begin
        in_data = 16'($urandom);
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(in_data);
      @(negedge clk);
      cyc++;
    end
    if (acc) sent++;
    in_valid = 1'b0;
    void'(check("s6_words_sent", 32'(sent), 32'd1000));
    repeat (30) @(negedge clk);
    cap_en = 1'b0;
    idle_chk_en = 1'b0;
    void'(check("s6_nibble_count", 32'(got_q.size()), 32'(4 * exp_q.size())));
    for (int i = 0; i < got_q.size() && i < 4 * exp_q.size(); i++) begin
      w = exp_q[i/4];
      if (!check("s6_nibble", 32'(got_q[i]), 32'(w[4*(i%4) +: 4]))) break;
    end
    void'(check("s6_final_level", 32'(fifo_level), 32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
